div_unit: RTL and testbench

Iterative 32-bit radix-2 divider for MIPS DIV/DIVU in the execute stage. It produces the `stall_divE` request consumed by the hazard unit and holds the E stage until the quotient and remainder are ready. The 64-bit `{hi, lo}` result feeds the HI/LO write path in M.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_unit.sv | 102 ++++++++++
 tb/tb_div_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
//   state_t         FSM encoding {IDLE, BUSY, DONE}
//   DIV_CYCLES      iteration count for 32-bit operands
//   DIV_ZERO_RESULT {hi, lo} produced when the divisor is zero
//   abs32           magnitude of a 32-bit value, only when treated as signed
package div_pkg;

    localparam int DIV_CYCLES = 32;
    localparam logic [63:0] DIV_ZERO_RESULT = 64'h0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // 0x80000000 maps onto itself, which is the correct magnitude read unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed & v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
//   clk, rst    clock, asynchronous active-high reset
//   start       DIV/DIVU present in E (held while E is stalled)
//   signed_div  1 = DIV, 0 = DIVU, sampled with start
//   annul       flush; cancels any operation, wins over start
//   a, b        dividend, divisor
//   stall_div   stall request to the hazard unit
//   ready       one-cycle pulse, result valid
//   result      {remainder, quotient} for HI/LO
module div_unit
    import div_pkg::*;
#(
    parameter int DIV_CYCLES = div_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall_div,
    output logic        ready,
    output logic [63:0] result
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [31:0] rem, quo, bd;
    logic neg_a, neg_b;
    logic [63:0] result_q;

    // One restoring step: bring in the next dividend bit, keep the
    // difference only when the shifted remainder covers the divisor.
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] sub;
    logic [31:0] q_fix, r_fix;

    assign shifted = {rem, quo[31]};
    assign fits    = shifted >= {1'b0, bd};
    assign sub     = shifted[31:0] - bd;
    // neg_a/neg_b are already gated by signed_div, so DIVU never negates.
    assign q_fix   = (neg_a ^ neg_b) ? -quo : quo;
    assign r_fix   = neg_a ? -rem : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (b == '0) ? DONE : BUSY;
            BUSY:    if (cnt == LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (annul)
            state_next = IDLE;
    end

    // result is bypassed during DONE so it is valid alongside ready; the
    // register only captures it when the pulse is not annulled.
    always_comb begin
        stall_div = ~rst & ~annul & ((start & state == IDLE) | state == BUSY);
        ready     = state == DONE & ~annul;
        result    = ready ? {r_fix, q_fix} : result_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            bd       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_q <= '0;
        end else begin
            if (state == IDLE && start && !annul) begin
                neg_a      <= signed_div & a[31];
                neg_b      <= signed_div & b[31];
                bd         <= abs32(b, signed_div);
                cnt        <= '0;
                {rem, quo} <= (b == '0) ? DIV_ZERO_RESULT : {32'h0, abs32(a, signed_div)};
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                rem <= fits ? sub : shifted[31:0];
                quo <= {quo[30:0], fits};
            end
            if (ready)
                result_q <= {r_fix, q_fix};
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit against a cycle-level reference model.
module tb_div_unit;

    localparam int NCYC = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall_div;
    logic        ready;
    logic [63:0] result;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_div(signed_div),
        .annul(annul),
        .a(a),
        .b(b),
        .stall_div(stall_div),
        .ready(ready),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural result of DIV/DIVU using plain integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sg);
        longint sx, sy, q, r;
        if (y == 0) return 64'h0;
        if (!sg) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Reference timing: an accepted divide answers after NCYC+1 cycles
    // (1 for a zero divisor); flush and reset drop it without a pulse.
    int          m_wait = 0;
    logic [63:0] m_exp = '0;
    logic [63:0] m_last = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_stall", 64'(stall_div), 64'd0);
            chk("rst_ready", 64'(ready), 64'd0);
            chk("rst_result", result, 64'd0);
            m_wait = 0;
            m_last = '0;
        end else if (annul) begin
            chk("annul_stall", 64'(stall_div), 64'd0);
            chk("annul_ready", 64'(ready), 64'd0);
            chk("annul_result", result, m_last);
            m_wait = 0;
        end else if (m_wait == 0) begin
            chk("idle_stall", 64'(stall_div), 64'(start));
            chk("idle_ready", 64'(ready), 64'd0);
            chk("idle_result", result, m_last);
            if (start) begin
                m_wait = (b == 0) ? 1 : NCYC + 1;
                m_exp  = model(a, b, signed_div);
            end
        end else if (m_wait == 1) begin
            chk("done_stall", 64'(stall_div), 64'd0);
            chk("done_ready", 64'(ready), 64'd1);
            chk("done_result", result, m_exp);
            m_last = m_exp;
            m_wait = 0;
        end else begin
            chk("busy_stall", 64'(stall_div), 64'd1);
            chk("busy_ready", 64'(ready), 64'd0);
            chk("busy_result", result, m_last);
            m_wait--;
        end
    end

    // Issue one divide with start held until ready, then check the literal
    // answer, the ready latency and the number of stalled cycles.
    task automatic do_div(input logic [31:0] xa, input logic [31:0] xb, input logic sg,
                          input logic [63:0] exp, input int lat, input string name);
        int cyc = 0;
        int st = 0;
        bit got = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = xa;
        b = xb;
        signed_div = sg;
        while (!got && cyc < 40) begin
            @(negedge clk);
            st += int'(stall_div);
            if (ready) begin
                got = 1;
                chk({name, "_result"}, result, exp);
            end else begin
                cyc++;
            end
        end
        chk({name, "_latency"}, 64'(cyc), 64'(lat));
        chk({name, "_stall_cycles"}, 64'(st), 64'(lat));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7");
        idle();
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div_m7_2");
        do_div(32'hFFFFFFF9, 32'd2, 1'b0, {32'd1, 32'h7FFFFFFC}, 33, "divu_m7_2");
        idle();
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, "div_min_m1");
        idle();
        do_div(32'h1234, 32'd0, 1'b0, 64'h0, 1, "divu_by0");
        idle();
        do_div(32'd100, 32'hFFFFFFF9, 1'b1, {32'd2, 32'hFFFFFFF2}, 33, "div_100_m7");
        do_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'h0000000E}, 33, "div_m100_m7");
        do_div(32'h1234, 32'd0, 1'b1, 64'h0, 1, "div_by0");
        do_div(32'd0, 32'd5, 1'b1, 64'h0, 33, "div_zero_dividend");
        do_div(32'hFFFFFFFF, 32'h10, 1'b0, {32'hF, 32'h0FFFFFFF}, 33, "divu_max_16");
        idle();

        // Flush in BUSY cycle 10: no pulse, result keeps the previous answer.
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 32'd1000;
        b = 32'd3;
        signed_div = 1'b0;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        chk("annul_cycle_stall", 64'(stall_div), 64'd0);
        chk("annul_cycle_ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_annul_stall", 64'(stall_div), 64'd0);
        chk("post_annul_ready", 64'(ready), 64'd0);
        chk("post_annul_result", result, {32'hF, 32'h0FFFFFFF});
        do_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, "divu_after_annul");
        idle();

        // Asynchronous reset in BUSY cycle 5 clears everything immediately.
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 32'd1000;
        b = 32'd7;
        signed_div = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_stall", 64'(stall_div), 64'd0);
        chk("async_rst_ready", 64'(ready), 64'd0);
        chk("async_rst_result", result, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;

        do_div(32'd20, 32'd3, 1'b0, {32'd2, 32'd6}, 33, "b2b_20_3");
        do_div(32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 33, "b2b_9_4");
        idle();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
